counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven 8-bit counter with a programmable
// prescaler, compare match, wrap detection and an optional one-shot mode.
// Commands arrive on a valid/ready handshake, are latched on acceptance and
// executed on the following clock edge, so at most one command is accepted
// every two cycles.
//
// Optional feature: define COUNTER_SEQ_DIR_EN to enable down counting,
// selected by SET_MODE operand bit 1. Without the macro the counter only
// counts up and no down-count logic exists.

module counter_sequencer #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [15:0]           cmd_data,
   output logic [7:0]            cnt,
   output logic                  match,
   output logic                  wrap,
   output logic                  running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP          = 3'd0,
      OP_START        = 3'd1,
      OP_STOP         = 3'd2,
      OP_LOAD         = 3'd3,
      OP_SET_PRESCALE = 3'd4,
      OP_SET_COMPARE  = 3'd5,
      OP_SET_MODE     = 3'd6,
      OP_CLEAR        = 3'd7
   } op_t;

   state_t                state_q;
   logic [7:0]            cnt_q;
   logic [PRESCALE_W-1:0] pre_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [7:0]            compare_q;
   logic                  oneShot_q;
`ifdef COUNTER_SEQ_DIR_EN
   logic                  countDown_q;
`endif
   logic                  pendValid_q;
   op_t                   pendOp_q;
   logic [15:0]           pendData_q;
   logic                  ready_q;
   logic                  match_q;
   logic                  wrap_q;

   logic                  tick;
   logic [7:0]            cntNext_d;
   logic                  wrapHit;
   logic                  cmdExec;
   logic                  unusedData;

   // Only part of the operand is meaningful for any opcode; the rest is
   // deliberately ignored.
   assign unusedData = ^pendData_q;

   // Tick and next count value; a non-NOP command executing on this edge
   // takes priority over the tick, so the tick path is bypassed then.
   always_comb begin
      tick    = (state_q == RUN) && (pre_q == prescale_q);
      cmdExec = pendValid_q && (pendOp_q != OP_NOP);
`ifdef COUNTER_SEQ_DIR_EN
      cntNext_d = countDown_q ? (cnt_q - 8'd1) : (cnt_q + 8'd1);
      wrapHit   = countDown_q ? (cnt_q == 8'h00) : (cnt_q == 8'hFF);
`else
      cntNext_d = cnt_q + 8'd1;
      wrapHit   = (cnt_q == 8'hFF);
`endif
   end

   // Command handshake, command execution, prescaler and counter update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 8'h00;
         pre_q       <= '0;
         prescale_q  <= '0;
         compare_q   <= 8'hFF;
         oneShot_q   <= 1'b0;
`ifdef COUNTER_SEQ_DIR_EN
         countDown_q <= 1'b0;
`endif
         pendValid_q <= 1'b0;
         pendOp_q    <= OP_NOP;
         pendData_q  <= 16'h0000;
         ready_q     <= 1'b1;
         match_q     <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         match_q <= 1'b0;
         wrap_q  <= 1'b0;

         if (cmd_valid && ready_q) begin
            pendValid_q <= 1'b1;
            pendOp_q    <= op_t'(cmd_op);
            pendData_q  <= cmd_data;
            ready_q     <= 1'b0;
         end else begin
            pendValid_q <= 1'b0;
            ready_q     <= 1'b1;
         end

         if (state_q == RUN) begin
            pre_q <= tick ? '0 : pre_q + PRESCALE_W'(1);
         end else begin
            pre_q <= '0;
         end

         if (cmdExec) begin
            case (pendOp_q)
               OP_START: begin
                  state_q <= RUN;
                  pre_q   <= '0;
               end
               OP_STOP: begin
                  state_q <= IDLE;
                  pre_q   <= '0;
               end
               OP_LOAD: begin
                  cnt_q <= pendData_q[7:0];
                  pre_q <= '0;
               end
               OP_SET_PRESCALE: begin
                  prescale_q <= pendData_q[PRESCALE_W-1:0];
                  pre_q      <= '0;
               end
               OP_SET_COMPARE: begin
                  compare_q <= pendData_q[7:0];
                  pre_q     <= '0;
               end
               OP_SET_MODE: begin
                  oneShot_q   <= pendData_q[0];
`ifdef COUNTER_SEQ_DIR_EN
                  countDown_q <= pendData_q[1];
`endif
               end
               OP_CLEAR: begin
                  cnt_q <= 8'h00;
                  pre_q <= '0;
               end
               default: begin
               end
            endcase
         end else if (tick) begin
            cnt_q  <= cntNext_d;
            wrap_q <= wrapHit;
            if (cntNext_d == compare_q) begin
               match_q <= 1'b1;
               if (oneShot_q) begin
                  state_q <= DONE;
               end
            end
         end
      end
   end

   assign cmd_ready = ready_q;
   assign cnt       = cnt_q;
   assign match     = match_q;
   assign wrap      = wrap_q;
   assign running   = (state_q == RUN);

endmodule
